// File: rtl/div_pkg.sv
// Shared width constant and FSM state encoding for the restoring divider.
package div_pkg;

   localparam int unsigned DIV_N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div_16by8_if.sv
// Start/done handshake and operand/result bundle of the divider.
interface div_16by8_if
   import div_pkg::*;
#(
   parameter int unsigned N = DIV_N
);

   logic           start;
   logic [2*N-1:0] Dividend;
   logic [N-1:0]   Divisor;
   logic [N-1:0]   Quotient;
   logic [N-1:0]   Remainder;
   logic           fimOperacao;
   logic           Z;
   logic           OV;
   logic           DZ;

   modport master (
      output start, Dividend, Divisor,
      input  Quotient, Remainder, fimOperacao, Z, OV, DZ
   );

   modport slave (
      input  start, Dividend, Divisor,
      output Quotient, Remainder, fimOperacao, Z, OV, DZ
   );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted partial remainder.
module div_restore_step #(
   parameter int unsigned N = 8
) (
   input  logic [N:0]   r_shift_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   r_next_o,
   output logic         q_bit_o
);

   logic [N:0] trial_d;

   always_comb begin
      // NOTE: every output is given a default before the if, so no latch is inferred.
      r_next_o = r_shift_i;
      trial_d  = r_shift_i - {1'b0, divisor_i};
      q_bit_o  = (r_shift_i >= {1'b0, divisor_i});
      if (q_bit_o) begin
         r_next_o = trial_d;
      end
   end

endmodule

// File: rtl/div_16by8.sv
// Sequential restoring 2N/N divider, one quotient bit per cycle, fixed N+1 cycle latency.
module div_16by8
   import div_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic     clk,
   input  logic     rst,
   div_16by8_if.slave bus
);

   localparam int unsigned CW = $clog2(N) + 1;

   state_e         state_q;
   logic [CW-1:0]  count_q;
   logic [N-1:0]   divisor_q;
   logic [N:0]     r_q;
   logic [N-1:0]   low_q;
   logic           exc_dz_q;
   logic           exc_ov_q;
   logic [N-1:0]   quotient_q;
   logic [N-1:0]   remainder_q;
   logic           fim_q;
   logic           z_q;
   logic           ov_q;
   logic           dz_q;

   logic [N:0]     r_shift_d;
   logic [N:0]     r_next_d;
   logic           q_bit_d;

   assign r_shift_d = {r_q[N-1:0], low_q[N-1]};

   div_restore_step #(.N(N)) u_step (
      .r_shift_i (r_shift_d),
      .divisor_i (divisor_q),
      .r_next_o  (r_next_d),
      .q_bit_o   (q_bit_d)
   );

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         divisor_q   <= '0;
         r_q         <= '0;
         low_q       <= '0;
         exc_dz_q    <= 1'b0;
         exc_ov_q    <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         fim_q       <= 1'b0;
         z_q         <= 1'b0;
         ov_q        <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  divisor_q <= bus.Divisor;
                  exc_dz_q  <= (bus.Divisor == '0);
                  exc_ov_q  <= (bus.Dividend[2*N-1:N] >= bus.Divisor);
                  fim_q     <= 1'b0;
                  count_q   <= '0;
                  r_q       <= {1'b0, bus.Dividend[2*N-1:N]};
                  low_q     <= bus.Dividend[N-1:0];
                  state_q   <= RUN;
               end
            end
            RUN: begin
               r_q     <= r_next_d;
               low_q   <= {low_q[N-2:0], q_bit_d};
               count_q <= count_q + 1'b1;
               if (count_q == CW'(N - 1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               // A carry into R[N] is only possible once the quotient has already overflowed.
               if (exc_ov_q || r_q[N]) begin
                  quotient_q  <= '0;
                  remainder_q <= '0;
                  z_q         <= 1'b0;
                  ov_q        <= 1'b1;
                  dz_q        <= exc_dz_q;
               end else begin
                  quotient_q  <= low_q;
                  remainder_q <= r_q[N-1:0];
                  z_q         <= (low_q == '0);
                  ov_q        <= 1'b0;
                  dz_q        <= 1'b0;
               end
               fim_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Quotient    = quotient_q;
   assign bus.Remainder   = remainder_q;
   assign bus.fimOperacao = fim_q;
   assign bus.Z           = z_q;
   assign bus.OV          = ov_q;
   assign bus.DZ          = dz_q;

endmodule
